// File: rtl/easy_cpu_mul_pkg.sv
// rtl/easy_cpu_mul_pkg.sv - widths, op codes and FSM encoding for the multiplier sequencer
package easy_cpu_mul_pkg;

   localparam int DATA_W = 32;
   localparam int CELL_W = 16;

   localparam logic [1:0] OP_MUL    = 2'd0;
   localparam logic [1:0] OP_MULXUU = 2'd1;
   localparam logic [1:0] OP_MULXSU = 2'd2;
   localparam logic [1:0] OP_MULXSS = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_P1   = 2'd1;
   localparam logic [1:0] ST_P2   = 2'd2;
   localparam logic [1:0] ST_RSP  = 2'd3;

   // MULXSU and MULXSS treat operand a as two's complement.
   function automatic logic op_signed_a(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/easy_cpu_cpu_mul_seq_if.sv
// rtl/easy_cpu_cpu_mul_seq_if.sv - request, response and multiplier-cell bus of the sequencer
interface easy_cpu_cpu_mul_seq_if;

   logic                                   req_valid;
   logic                                   req_ready;
   logic [1:0]                             req_op;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    req_a;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    req_b;
   logic                                   rsp_valid;
   logic                                   rsp_ready;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    rsp_result;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    cell_src1;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    cell_src2;
   logic                                   cell_en;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    cell_p1;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    cell_p2;
   logic [easy_cpu_mul_pkg::DATA_W-1:0]    cell_p3;

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
      output req_ready, rsp_valid, rsp_result, cell_src1, cell_src2, cell_en
   );

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
      input  req_ready, rsp_valid, rsp_result, cell_src1, cell_src2, cell_en
   );

endinterface

// File: rtl/easy_cpu_mul_combine.sv
// rtl/easy_cpu_mul_combine.sv - partial-product adder tree; MULT_SIGNED_HI_EN adds signed high-word correction
module easy_cpu_mul_combine
   import easy_cpu_mul_pkg::*;
(
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] p1,
   input  logic [DATA_W-1:0] p2,
   input  logic [DATA_W-1:0] p3,
   input  logic [CELL_W:0]   mid_hi_q,
   input  logic              lo_carry_q,
   output logic [CELL_W:0]   mid_hi,
   output logic [DATA_W:0]   lo33,
   output logic [DATA_W-1:0] hi
);

   logic [DATA_W:0]   mid;
   logic [DATA_W-1:0] hi_u;

   // First pass uses mid/lo33; second pass reuses p1 as a_hi*b_hi with the stored mid/carry.
   always_comb begin
      mid    = {1'b0, p2} + {1'b0, p3};
      lo33   = {1'b0, p1} + {1'b0, mid[CELL_W-1:0], {CELL_W{1'b0}}};
      mid_hi = mid[DATA_W:CELL_W];
      hi_u   = p1 + {{(DATA_W-CELL_W-1){1'b0}}, mid_hi_q}
                  + {{(DATA_W-1){1'b0}}, lo_carry_q};
   end

`ifdef MULT_SIGNED_HI_EN
   logic [DATA_W-1:0] corr_a;
   logic [DATA_W-1:0] corr_b;

   always_comb begin
      corr_a = (op_signed_a(op) && a[DATA_W-1]) ? b : '0;
      corr_b = ((op == OP_MULXSS) && b[DATA_W-1]) ? a : '0;
      hi     = hi_u - corr_a - corr_b;
   end
`else
   logic unused_sign_inputs;
   assign unused_sign_inputs = ^{op, a, b};
   assign hi = hi_u;
`endif

endmodule

// File: rtl/easy_cpu_cpu_mul_seq.sv
// rtl/easy_cpu_cpu_mul_seq.sv - 32x32 multiply sequencer over a 3-product 16x16 cell (option: MULT_SIGNED_HI_EN)
module easy_cpu_cpu_mul_seq
   import easy_cpu_mul_pkg::*;
(
   input logic                   clk,
   input logic                   reset_n,
   easy_cpu_cpu_mul_seq_if.slave bus
);

   logic [1:0]        state;
   logic [1:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic              rsp_valid_q;
   logic [CELL_W:0]   mid_hi_q;
   logic              lo_carry_q;
   logic [CELL_W:0]   mid_hi;
   logic [DATA_W:0]   lo33;
   logic [DATA_W-1:0] hi;
   logic              req_fire;
   logic              second_pass;

   assign req_fire    = (state == ST_IDLE) && bus.req_valid;
   assign second_pass = (state == ST_P1) && (op_q != OP_MUL);

   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.cell_en    = req_fire || second_pass;

   // Outside IDLE the cell only ever sees the high halves (a_hi*b_hi pass).
   assign bus.cell_src1 = (state == ST_IDLE) ? bus.req_a
                                             : {{CELL_W{1'b0}}, a_q[DATA_W-1:CELL_W]};
   assign bus.cell_src2 = (state == ST_IDLE) ? bus.req_b
                                             : {{CELL_W{1'b0}}, b_q[DATA_W-1:CELL_W]};

   easy_cpu_mul_combine u_combine (
      .op         (op_q),
      .a          (a_q),
      .b          (b_q),
      .p1         (bus.cell_p1),
      .p2         (bus.cell_p2),
      .p3         (bus.cell_p3),
      .mid_hi_q   (mid_hi_q),
      .lo_carry_q (lo_carry_q),
      .mid_hi     (mid_hi),
      .lo33       (lo33),
      .hi         (hi)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mid_hi_q     <= '0;
         lo_carry_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  op_q  <= bus.req_op;
                  a_q   <= bus.req_a;
                  b_q   <= bus.req_b;
                  state <= ST_P1;
               end
            end
            ST_P1: begin
               mid_hi_q   <= mid_hi;
               lo_carry_q <= lo33[DATA_W];
               if (op_q == OP_MUL) begin
                  rsp_result_q <= lo33[DATA_W-1:0];
                  rsp_valid_q  <= 1'b1;
                  state        <= ST_RSP;
               end else begin
                  state <= ST_P2;
               end
            end
            ST_P2: begin
               rsp_result_q <= hi;
               rsp_valid_q  <= 1'b1;
               state        <= ST_RSP;
            end
            ST_RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_easy_cpu_cpu_mul_seq.sv
// tb/tb_easy_cpu_cpu_mul_seq.sv - directed bench for the multiply sequencer with a behavioural 16x16 cell
module tb_easy_cpu_cpu_mul_seq;
   import easy_cpu_mul_pkg::*;

   logic clk;
   logic reset_n;
   int   n_vec = 0;
   int   n_bad = 0;
   int   lat;
   int   en_cnt;
   logic [31:0] s1;
   logic [31:0] s2;

`ifdef MULT_SIGNED_HI_EN
   localparam logic [31:0] EXP_SS = 32'h0000_0000;
   localparam logic [31:0] EXP_SU = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] EXP_SS = 32'hFFFF_FFFE;
   localparam logic [31:0] EXP_SU = 32'h0000_0001;
`endif

   logic [31:0] va [3] = '{32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
   logic [31:0] vb [3] = '{32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'h8000_0001};

   easy_cpu_cpu_mul_seq_if bus ();

   easy_cpu_cpu_mul_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 16x16 cell: products registered one cycle after cell_en, cleared with reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.cell_p1 <= '0;
         bus.cell_p2 <= '0;
         bus.cell_p3 <= '0;
      end else if (bus.cell_en) begin
         bus.cell_p1 <= {16'h0, bus.cell_src1[15:0]}  * {16'h0, bus.cell_src2[15:0]};
         bus.cell_p2 <= {16'h0, bus.cell_src1[15:0]}  * {16'h0, bus.cell_src2[31:16]};
         bus.cell_p3 <= {16'h0, bus.cell_src1[31:16]} * {16'h0, bus.cell_src2[15:0]};
      end
   end

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'h0, a} * {32'h0, b};
`ifdef MULT_SIGNED_HI_EN
      if (op == OP_MULXSU) p = {{32{a[31]}}, a} * {32'h0, b};
      if (op == OP_MULXSS) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`endif
      return (op == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int e, output logic [31:0] c1, output logic [31:0] c2);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      #1;
      check("acc_ready", {31'h0, bus.req_ready}, 32'd1);
      check("acc_cell_en", {31'h0, bus.cell_en}, 32'd1);
      e  = 1;
      c1 = '0;
      c2 = '0;
      @(posedge clk);
      l = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      while (!bus.rsp_valid && l < 8) begin
         if (bus.cell_en) begin
            e++;
            c1 = bus.cell_src1;
            c2 = bus.cell_src2;
         end
         @(posedge clk);
         l++;
         @(negedge clk);
         #1;
      end
      check("rsp_valid_seen", {31'h0, bus.rsp_valid}, 32'd1);
      check("rsp_cell_en", {31'h0, bus.cell_en}, 32'd0);
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("drain_valid", {31'h0, bus.rsp_valid}, 32'd0);
      check("drain_ready", {31'h0, bus.req_ready}, 32'd1);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_result", bus.rsp_result, 32'h0);
      check("rst_cell_en", {31'h0, bus.cell_en}, 32'd0);

      issue(OP_MUL, 32'h0001_0003, 32'h0002_0005, lat, en_cnt, s1, s2);
      check("mul_result", bus.rsp_result, 32'h000B_000F);
      check("mul_latency", lat, 2);
      check("mul_en_pulses", en_cnt, 1);
      consume();

      issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, en_cnt, s1, s2);
      check("mulxuu_result", bus.rsp_result, 32'hFFFF_FFFE);
      check("mulxuu_latency", lat, 3);
      check("mulxuu_en_pulses", en_cnt, 2);
      check("mulxuu_src1_p2", s1, 32'h0000_FFFF);
      check("mulxuu_src2_p2", s2, 32'h0000_FFFF);
      consume();

      issue(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, en_cnt, s1, s2);
      check("mulxss_result", bus.rsp_result, EXP_SS);
      consume();

      // rsp_ready already high before the result exists
      bus.rsp_ready = 1'b1;
      issue(OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, lat, en_cnt, s1, s2);
      check("mulxsu_result", bus.rsp_result, EXP_SU);
      check("mulxsu_latency", lat, 3);
      consume();

      issue(OP_MUL, 32'd7, 32'd6, lat, en_cnt, s1, s2);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_MUL;
      bus.req_a     = 32'd9;
      bus.req_b     = 32'd9;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", {31'h0, bus.rsp_valid}, 32'd1);
         check("bp_result", bus.rsp_result, 32'h0000_002A);
         check("bp_req_ready", {31'h0, bus.req_ready}, 32'd0);
         check("bp_cell_en", {31'h0, bus.cell_en}, 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_exit_valid", {31'h0, bus.rsp_valid}, 32'd0);
      issue(OP_MUL, 32'd9, 32'd9, lat, en_cnt, s1, s2);
      check("bp_next_result", bus.rsp_result, 32'h0000_0051);
      check("bp_next_latency", lat, 2);
      consume();

      bus.req_valid = 1'b1;
      bus.req_op    = OP_MULXUU;
      bus.req_a     = 32'hFFFF_FFFF;
      bus.req_b     = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset_n       = 1'b0;
      #1;
      check("rst_p1_req_ready", {31'h0, bus.req_ready}, 32'd1);
      check("rst_p1_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
      check("rst_p1_cell_en", {31'h0, bus.cell_en}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("post_rst_valid", {31'h0, bus.rsp_valid}, 32'd0);
         check("post_rst_ready", {31'h0, bus.req_ready}, 32'd1);
      end
      issue(OP_MUL, 32'd3, 32'd5, lat, en_cnt, s1, s2);
      check("post_rst_mul", bus.rsp_result, 32'h0000_000F);
      consume();

      for (int op = 0; op < 4; op++) begin
         for (int i = 0; i < 3; i++) begin
            issue(op[1:0], va[i], vb[i], lat, en_cnt, s1, s2);
            check("model_result", bus.rsp_result, model(op[1:0], va[i], vb[i]));
            check("model_latency", lat, (op == 0) ? 2 : 3);
            consume();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
